// File: rtl/dsp_pkg.sv
// Shared FSM state type and signed arithmetic helpers for the sequential FIR datapath.
package dsp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_e;

  localparam int WIDE_W = 64;

  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  function automatic logic signed [WIDE_W-1:0] round_const(input int frac_bits);
    return 64'sd1 <<< (frac_bits - 1);
  endfunction

  function automatic logic signed [WIDE_W-1:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [WIDE_W-1:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic logic is_clipped(input logic signed [WIDE_W-1:0] v, input int w);
    return (v > sat_max(w)) || (v < sat_min(w));
  endfunction

  function automatic logic signed [WIDE_W-1:0] saturate(input logic signed [WIDE_W-1:0] v,
                                                        input int w);
    if (v > sat_max(w)) begin
      return sat_max(w);
    end else if (v < sat_min(w)) begin
      return sat_min(w);
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Runtime-writable coefficient register file; resets to a unity-gain identity filter.
module fir_coef_bank #(
  parameter int COEF_W    = 9,
  parameter int TAPS      = 8,
  parameter int FRAC_BITS = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(TAPS)-1:0]    wr_addr,
  input  logic signed [COEF_W-1:0]   wr_data,
  input  logic [$clog2(TAPS)-1:0]    rd_addr,
  output logic signed [COEF_W-1:0]   rd_data
);

  localparam int AW = $clog2(TAPS);
  localparam logic signed [COEF_W-1:0] UNITY = COEF_W'(32'sd1 <<< FRAC_BITS);

  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [COEF_W-1:0] coef_d [TAPS];

  // Next-state of each coefficient; addresses with no matching tap hit nothing.
  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      if (wr_en && (wr_addr == AW'(i))) begin
        coef_d[i] = wr_data;
      end else begin
        coef_d[i] = coef_q[i];
      end
    end
  end

  // Coefficient storage with identity reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i] <= (i == 0) ? UNITY : '0;
      end
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i] <= coef_d[i];
      end
    end
  end

  assign rd_data = coef_q[rd_addr];

endmodule

// File: rtl/fir_seq_mac.sv
// Time-multiplexed FIR: one shared MAC walks all taps per sample, then rounds/saturates.
module fir_seq_mac
  import dsp_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 9,
  parameter int TAPS      = 8,
  parameter int FRAC_BITS = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [DATA_W-1:0]  data_in,
  input  logic                      data_in_ready,
  input  logic                      coef_wr_en,
  input  logic [$clog2(TAPS)-1:0]   coef_wr_addr,
  input  logic signed [COEF_W-1:0]  coef_wr_data,
  input  logic                      bypass,
  output logic                      busy,
  output logic signed [DATA_W-1:0]  data_out,
  output logic                      data_out_flag,
  output logic                      sat_flag,
  output logic                      overrun
);

  localparam int AW     = $clog2(TAPS);
  localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS);
  localparam int PROD_W = DATA_W + COEF_W;

  fir_state_e state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [DATA_W-1:0] x_q [TAPS];
  logic signed [DATA_W-1:0] x_d [TAPS];
  logic signed [DATA_W-1:0] data_out_q, data_out_d;
  logic flag_q, flag_d, sat_q, sat_d, overrun_q, overrun_d, busy_q, busy_d;

  logic signed [COEF_W-1:0] coef_s;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [WIDE_W-1:0] rounded_s;
  logic coef_we_s;

  // Writes land only while idle, so an in-flight sample never sees a mixed coefficient set.
  assign coef_we_s = coef_wr_en && (state_q == IDLE);

  fir_coef_bank #(
    .COEF_W   (COEF_W),
    .TAPS     (TAPS),
    .FRAC_BITS(FRAC_BITS)
  ) u_coef_bank (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (coef_we_s),
    .wr_addr(coef_wr_addr),
    .wr_data(coef_wr_data),
    .rd_addr(k_q),
    .rd_data(coef_s)
  );

  assign prod_s    = x_q[k_q] * coef_s;
  assign rounded_s = (WIDE_W'(acc_q) + round_const(FRAC_BITS)) >>> FRAC_BITS;

  // FSM, delay line, accumulator and output next-state.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    acc_d      = acc_q;
    x_d        = x_q;
    data_out_d = data_out_q;
    flag_d     = 1'b0;
    sat_d      = sat_q;
    case (state_q)
      IDLE: begin
        if (data_in_ready) begin
          x_d[0] = data_in;
          for (int i = 1; i < TAPS; i++) begin
            x_d[i] = x_q[i-1];
          end
          acc_d   = '0;
          k_d     = '0;
          state_d = MAC;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        acc_d = acc_q + ACC_W'(prod_s);
        if (k_q == AW'(TAPS - 1)) begin
          state_d = OUT;
        end else begin
          k_d = k_q + AW'(32'd1);
        end
      end
      OUT: begin
        if (bypass) begin
          data_out_d = x_q[0];
          sat_d      = 1'b0;
        end else begin
          data_out_d = DATA_W'(saturate(rounded_s, DATA_W));
          sat_d      = is_clipped(rounded_s, DATA_W);
        end
        flag_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (data_in_ready && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      acc_q      <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
      end
      data_out_q <= '0;
      flag_q     <= 1'b0;
      sat_q      <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      x_q        <= x_d;
      data_out_q <= data_out_d;
      flag_q     <= flag_d;
      sat_q      <= sat_d;
      overrun_q  <= overrun_d;
      busy_q     <= busy_d;
    end
  end

  assign busy          = busy_q;
  assign data_out      = data_out_q;
  assign data_out_flag = flag_q;
  assign sat_flag      = sat_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_fir_seq_mac.sv
// Directed plus randomized bench for fir_seq_mac against an arithmetic reference model.
module tb_fir_seq_mac;

  localparam int DATA_W    = 16;
  localparam int COEF_W    = 9;
  localparam int TAPS      = 8;
  localparam int FRAC_BITS = 7;
  localparam int AW        = $clog2(TAPS);

  logic                     clk = 1'b0;
  logic                     reset;
  logic signed [DATA_W-1:0] data_in;
  logic                     data_in_ready;
  logic                     coef_wr_en;
  logic [AW-1:0]            coef_wr_addr;
  logic signed [COEF_W-1:0] coef_wr_data;
  logic                     bypass;
  logic                     busy;
  logic signed [DATA_W-1:0] data_out;
  logic                     data_out_flag;
  logic                     sat_flag;
  logic                     overrun;

  int checks = 0;
  int errors = 0;

  int     mcoef [TAPS];
  longint hist  [TAPS];

  fir_seq_mac #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .FRAC_BITS(FRAC_BITS)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_in_ready(data_in_ready),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .bypass(bypass), .busy(busy), .data_out(data_out), .data_out_flag(data_out_flag),
    .sat_flag(sat_flag), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < TAPS; i++) begin
      mcoef[i] = (i == 0) ? (1 << FRAC_BITS) : 0;
      hist[i]  = 0;
    end
  endfunction

  function automatic void model_push(input longint v);
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = v;
  endfunction

  // Filter output = round-half-up(sum x*c / 2^FRAC), clipped to the sample range.
  function automatic void model_eval(input logic byp, output longint e_out, output longint e_sat);
    longint acc, r, hi, lo;
    hi = (64'sd1 <<< (DATA_W - 1)) - 1;
    lo = -(64'sd1 <<< (DATA_W - 1));
    acc = 0;
    for (int i = 0; i < TAPS; i++) acc += hist[i] * mcoef[i];
    r = (acc + (64'sd1 <<< (FRAC_BITS - 1))) >>> FRAC_BITS;
    if (byp) begin
      e_out = hist[0]; e_sat = 0;
    end else if (r > hi) begin
      e_out = hi; e_sat = 1;
    end else if (r < lo) begin
      e_out = lo; e_sat = 1;
    end else begin
      e_out = r; e_sat = 0;
    end
  endfunction

  task automatic write_coef(input int addr, input int val);
    coef_wr_en = 1'b1; coef_wr_addr = AW'(addr); coef_wr_data = COEF_W'(val);
    @(negedge clk);
    coef_wr_en = 1'b0;
    mcoef[addr] = val;
  endtask

  task automatic set_all_coef(input int val);
    for (int i = 0; i < TAPS; i++) write_coef(i, val);
  endtask

  // One accepted sample, optionally with a same-cycle coefficient write; checks timing and value.
  task automatic run_sample(input string tag, input longint v, input logic byp,
                            input logic wr, input int wa, input int wd);
    longint e_out, e_sat;
    int n;
    if (wr) mcoef[wa] = wd;
    model_push(v);
    model_eval(byp, e_out, e_sat);
    coef_wr_en = wr; coef_wr_addr = AW'(wa); coef_wr_data = COEF_W'(wd);
    data_in = DATA_W'(v); data_in_ready = 1'b1; bypass = byp;
    @(negedge clk);
    data_in_ready = 1'b0; coef_wr_en = 1'b0;
    n = 1;
    check({tag, "_busy"}, busy, 1);
    while (!data_out_flag && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, TAPS + 2);
    check({tag, "_data"}, data_out, e_out);
    check({tag, "_sat"}, sat_flag, e_sat);
    @(negedge clk);
    bypass = 1'b0;
    check({tag, "_pulse"}, data_out_flag, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    longint e_out, e_sat;
    int n, pulses;
    reset = 1'b1; data_in = '0; data_in_ready = 1'b0; coef_wr_en = 1'b0;
    coef_wr_addr = '0; coef_wr_data = '0; bypass = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_data", data_out, 0);
    check("rst_flag", data_out_flag, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);

    run_sample("ident", 100, 1'b0, 1'b0, 0, 0);

    set_all_coef(64);
    for (int i = 0; i < TAPS; i++) run_sample("half", 1000, 1'b0, 1'b0, 0, 0);
    check("half_final", data_out, 4000);

    set_all_coef(0);
    write_coef(0, 1);
    run_sample("rnd_up", 64, 1'b0, 1'b0, 0, 0);
    check("rnd_up_val", data_out, 1);
    run_sample("rnd_dn", 63, 1'b0, 1'b0, 0, 0);
    check("rnd_dn_val", data_out, 0);
    write_coef(0, -128);
    run_sample("neg", 5, 1'b0, 1'b0, 0, 0);
    check("neg_val", data_out, -5);

    set_all_coef(255);
    for (int i = 0; i < TAPS; i++) run_sample("sat_hi", 32767, 1'b0, 1'b0, 0, 0);
    check("sat_hi_val", data_out, 32767);
    for (int i = 0; i < TAPS; i++) run_sample("sat_lo", -32768, 1'b0, 1'b0, 0, 0);
    check("sat_lo_val", data_out, -32768);
    check("sat_lo_flag", sat_flag, 1);

    // Second strobe and a coefficient write at E3 are both dropped while busy.
    set_all_coef(0);
    write_coef(0, 128);
    model_push(300);
    model_eval(1'b0, e_out, e_sat);
    data_in = 16'sd300; data_in_ready = 1'b1;
    @(negedge clk);
    data_in_ready = 1'b0;
    repeat (2) @(negedge clk);
    data_in = 16'sd999; data_in_ready = 1'b1;
    coef_wr_en = 1'b1; coef_wr_addr = '0; coef_wr_data = 9'sd0;
    @(negedge clk);
    data_in_ready = 1'b0; coef_wr_en = 1'b0;
    check("ovr_set", overrun, 1);
    n = 0;
    while (!data_out_flag && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ovr_flag_seen", data_out_flag, 1);
    check("ovr_data", data_out, e_out);
    @(negedge clk);
    run_sample("ovr_next", 300, 1'b0, 1'b0, 0, 0);
    check("ovr_coef_kept", data_out, 300);
    run_sample("byp", -7, 1'b1, 1'b0, 0, 0);
    check("byp_val", data_out, -7);
    check("ovr_sticky", overrun, 1);

    run_sample("wr_same", 200, 1'b0, 1'b1, 0, 64);
    check("wr_same_val", data_out, 100);

    // Reset sampled at E4 of a MAC sequence.
    data_in = 16'sd555; data_in_ready = 1'b1;
    @(negedge clk);
    data_in_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("mrst_busy", busy, 0);
    check("mrst_ovr", overrun, 0);
    check("mrst_data", data_out, 0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (data_out_flag) pulses++;
      @(negedge clk);
    end
    check("mrst_no_pulse", pulses, 0);
    run_sample("mrst_ident", 100, 1'b0, 1'b0, 0, 0);
    check("mrst_ident_val", data_out, 100);

    for (int it = 0; it < 30; it++) begin
      int nw;
      logic signed [COEF_W-1:0] c;
      logic signed [DATA_W-1:0] d;
      nw = int'($urandom_range(0, 2));
      for (int w = 0; w < nw; w++) begin
        c = COEF_W'($urandom_range(0, 511));
        write_coef(int'($urandom_range(0, TAPS - 1)), int'(c));
      end
      c = COEF_W'($urandom_range(0, 511));
      d = DATA_W'($urandom);
      run_sample("rand", longint'(d), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 3) == 0), int'($urandom_range(0, TAPS - 1)), int'(c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
